spi_cmd_ram: RTL and testbench
==============================

// Module: spi_cmd_ram
// PURPOSE
//   Command-driven byte RAM directly downstream of the SPI slave. Consumes its 10-bit
//   rx_data/rx_valid words: {cmd[1:0], payload[7:0]}. Executes address-set, write and
//   read commands. Returns read bytes on dout/tx_valid, which feed the slave's tx_data/tx_valid.
// PARAMETERS
//   ADDR_W     8    address width; memory depth = 2**ADDR_W bytes
//   AUTO_INC   0    1: wr_addr/rd_addr post-increment (mod 2**ADDR_W) after each data access
// PORTS
//   clk        in   1       single clock, rising-edge
//   rst_n      in   1       asynchronous active-low reset
//   din        in   10      command word from SPI slave rx_data: [9:8] cmd, [7:0] payload
//   rx_valid   in   1       din valid strobe from SPI slave
//   dout       out  8       read byte to SPI slave tx_data
//   tx_valid   out  1       dout valid to SPI slave
//   cmd_err    out  1       1-cycle pulse: data command issued with no address set
// BEHAVIOUR
//   Reset (async, rst_n=0): dout=8'h00, tx_valid=0, cmd_err=0, wr_addr=rd_addr=0,
//     wr_addr_ok=rd_addr_ok=0, rx_valid_d=0. Memory contents are not reset.
//   Accept: a command is accepted only on the rising edge of rx_valid
//     (rx_valid=1 && rx_valid_d=0, where rx_valid_d is rx_valid registered one cycle).
//     rx_valid held high for N cycles yields exactly one command.
//   Decode on accept (din[7:0] = payload):
//     2'b00 WR_ADDR: wr_addr<=payload[ADDR_W-1:0]; wr_addr_ok<=1
//     2'b01 WR_DATA: if wr_addr_ok: mem[wr_addr]<=payload; if AUTO_INC, wr_addr++
//                    else: no write; cmd_err pulses
//     2'b10 RD_ADDR: rd_addr<=payload[ADDR_W-1:0]; rd_addr_ok<=1
//     2'b11 RD_DATA: if rd_addr_ok: dout<=mem[rd_addr]; tx_valid<=1; if AUTO_INC, rd_addr++
//                    else: dout unchanged, tx_valid<=0, cmd_err pulses
//     For ADDR_W>8, upper address bits are zero-extended from the payload.
//     For ADDR_W<8, upper payload bits are ignored.
//   Latency: each effect is visible at the edge following the accept edge.
//     dout/tx_valid update 1 cycle after the accept edge.
//   tx_valid: level output. It stays 1 with dout stable until the next accepted command
//     of any type, which clears it. RD_DATA re-asserts it in the same cycle,
//     so back-to-back reads keep tx_valid high.
//   cmd_err: exactly 1 cycle, in the cycle after the offending accept edge.
//   Wrap: with AUTO_INC, an address at 2**ADDR_W-1 wraps to 0. No flag is raised.
//   WR_DATA then RD_DATA to the same address on consecutive accepts returns the new byte.
//     Only one command executes per cycle, so there is no read/write collision.
//   Async reset mid-sequence: address-valid flags clear. The next data command
//     without a fresh address sets cmd_err.
//   FSM: none required beyond the edge detector and the wr_addr_ok/rd_addr_ok flags.
//     Implemented as a registered decode, single always block per register group.
// STRUCTURE
//   Package spi_ram_pkg: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10,
//     CMD_RD_DATA=2'b11; CMD_W=2; DATA_W=8.
//   Sub-module spi_ram_mem: synchronous single-port array (we, addr, wdata, rdata).
//     rdata is registered, giving 1-cycle read latency. No reset on the array.
//   Top: edge detect, command decode, address registers, tx_valid/cmd_err logic.
// TESTING
//   1 Reset: rst_n=0 mid-traffic -> dout=00, tx_valid=0, cmd_err=0 immediately (async).
//   2 Write/read: 0x0_2A, 0x1_5C, 0x2_2A, 0x3_xx -> dout=0x5C, tx_valid=1 one cycle after
//     the 4th accept; tx_valid held until the next command.
//   3 Held strobe: rx_valid high 5 cycles with din=0x1_11 after 0x0_03 -> one write only;
//     AUTO_INC=1 build: wr_addr=0x04, not 0x08.
//   4 No address: after reset, 0x3_00 -> cmd_err pulse, tx_valid=0;
//     0x1_FF -> cmd_err pulse, mem unchanged.
//   5 Wrap (AUTO_INC=1): 0x0_FF, 0x1_AA, 0x1_BB; 0x2_FF, 0x3_00, 0x3_00
//     -> dout 0xAA then 0xBB (address 0x00).
//   6 Back-to-back reads: three RD_DATA accepts spaced 2 cycles apart -> tx_valid stays
//     high throughout; dout updates on each.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared command encodings and widths for the SPI command RAM.
// Imported by the memory array and the command decoder.
package spi_ram_pkg;

  localparam int CMD_W  = 2;
  localparam int DATA_W = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous single-port byte array with a registered read port.
// The read register only loads on re, so it doubles as the held tx byte.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the output register is reset; array contents survive rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_cmd_ram.sv
// Command-driven byte RAM fed by the SPI slave rx word {cmd, payload}.
// Accepts one command per rx_valid rising edge; read data returns on dout/tx_valid.
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter bit AUTO_INC = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CMD_W+DATA_W-1:0] din,
  input  logic                    rx_valid,
  output logic [DATA_W-1:0]       dout,
  output logic                    tx_valid,
  output logic                    cmd_err
);

  logic              rx_valid_d;
  logic              accept;
  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] pl_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_addr_ok;
  logic              rd_addr_ok;
  logic              do_write;
  logic              do_read;
  logic              bad_cmd;
  logic [ADDR_W-1:0] mem_addr;

  assign cmd     = cmd_e'(din[CMD_W+DATA_W-1:DATA_W]);
  assign payload = din[DATA_W-1:0];
  assign accept  = rx_valid & ~rx_valid_d;

  generate
    if (ADDR_W > DATA_W) begin : g_addr_wide
      assign pl_addr = {{(ADDR_W-DATA_W){1'b0}}, payload};
    end else begin : g_addr_narrow
      assign pl_addr = payload[ADDR_W-1:0];
    end
  endgenerate

  assign do_write = accept && (cmd == CMD_WR_DATA) && wr_addr_ok;
  assign do_read  = accept && (cmd == CMD_RD_DATA) && rd_addr_ok;
  assign bad_cmd  = accept && (((cmd == CMD_WR_DATA) && !wr_addr_ok) ||
                               ((cmd == CMD_RD_DATA) && !rd_addr_ok));
  // At most one data command per cycle, so the single port never contends.
  assign mem_addr = do_read ? rd_addr : wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_valid_d <= 1'b0;
    else        rx_valid_d <= rx_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      wr_addr_ok <= 1'b0;
    end else if (accept && cmd == CMD_WR_ADDR) begin
      wr_addr    <= pl_addr;
      wr_addr_ok <= 1'b1;
    end else if (do_write && AUTO_INC) begin
      wr_addr    <= wr_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      rd_addr_ok <= 1'b0;
    end else if (accept && cmd == CMD_RD_ADDR) begin
      rd_addr    <= pl_addr;
      rd_addr_ok <= 1'b1;
    end else if (do_read && AUTO_INC) begin
      rd_addr    <= rd_addr + ADDR_W'(1);
    end
  end

  // tx_valid is a level: any accepted command clears it, a good read re-sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= bad_cmd;
      if (accept) tx_valid <= do_read;
    end
  end

  spi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_write),
    .re    (do_read),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (dout)
  );

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Bench for spi_cmd_ram: two instances (AUTO_INC off/on) on shared stimulus,
// a per-cycle reference model, a directed vector table and random traffic.
module tb_spi_cmd_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout0, dout1;
  logic       tv0, tv1, err0, err1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_cmd_ram #(.ADDR_W(8), .AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout0), .tx_valid(tv0), .cmd_err(err0));

  spi_cmd_ram #(.ADDR_W(8), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout1), .tx_valid(tv1), .cmd_err(err1));

  // Reference model, index 0 = no auto-increment, 1 = auto-increment.
  logic [7:0] m_mem [2][256];
  logic [7:0] m_wa [2], m_ra [2], m_dout [2];
  bit         m_wok [2], m_rok [2], m_tv [2], m_err [2];
  bit         m_prev;

  // Outputs of both instances captured right after each accept.
  logic [7:0] s_dout0, s_dout1;
  logic       s_tv0, s_tv1, s_err0, s_err1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0;
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_dout[i] = 0;
      m_wok[i] = 0; m_rok[i] = 0; m_tv[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_clock();
    bit acc;
    logic [1:0] c;
    logic [7:0] p;
    acc = rx_valid && !m_prev;
    m_prev = rx_valid;
    c = din[9:8];
    p = din[7:0];
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      if (acc) begin
        m_tv[i] = 0;
        case (c)
          2'd0: begin m_wa[i] = p; m_wok[i] = 1; end
          2'd1: if (m_wok[i]) begin
                  m_mem[i][m_wa[i]] = p;
                  if (i == 1) m_wa[i] = m_wa[i] + 8'd1;
                end else m_err[i] = 1;
          2'd2: begin m_ra[i] = p; m_rok[i] = 1; end
          default: if (m_rok[i]) begin
                  m_dout[i] = m_mem[i][m_ra[i]];
                  m_tv[i] = 1;
                  if (i == 1) m_ra[i] = m_ra[i] + 8'd1;
                end else m_err[i] = 1;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    chk("dout0", dout0, m_dout[0]);
    chk("tx_valid0", {7'd0, tv0}, {7'd0, m_tv[0]});
    chk("cmd_err0", {7'd0, err0}, {7'd0, m_err[0]});
    chk("dout1", dout1, m_dout[1]);
    chk("tx_valid1", {7'd0, tv1}, {7'd0, m_tv[1]});
    chk("cmd_err1", {7'd0, err1}, {7'd0, m_err[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_clock();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p, input int hold, input int gap);
    din = {c, p};
    rx_valid = 1'b1;
    tick();
    s_dout0 = dout0; s_tv0 = tv0; s_err0 = err0;
    s_dout1 = dout1; s_tv1 = tv1; s_err1 = err1;
    repeat (hold - 1) tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_tv0", {7'd0, tv0}, 8'h00);
    chk("rst_err0", {7'd0, err0}, 8'h00);
    chk("rst_dout1", dout1, 8'h00);
    chk("rst_tv1", {7'd0, tv1}, 8'h00);
    chk("rst_err1", {7'd0, err1}, 8'h00);
    model_reset();
    rx_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pl;
    int         hold;
    logic [7:0] exp_dout;
    logic       exp_tv;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Expectations for the AUTO_INC=0 instance, sampled one cycle after each accept.
    vecs[0]  = '{2'd3, 8'h00, 1, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{2'd1, 8'hFF, 1, 8'h00, 1'b0, 1'b1};
    vecs[2]  = '{2'd2, 8'h00, 1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 8'h00, 1, 8'h5A, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 8'h2A, 1, 8'h5A, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 8'h5C, 1, 8'h5A, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 8'h2A, 1, 8'h5A, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, 8'h00, 1, 8'h5C, 1'b1, 1'b0};
    vecs[8]  = '{2'd0, 8'h03, 1, 8'h5C, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, 8'h11, 5, 8'h5C, 1'b0, 1'b0};
    vecs[10] = '{2'd2, 8'h03, 1, 8'h5C, 1'b0, 1'b0};

    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Fill every location with a known pattern: mem[a] = a ^ 5A.
    for (int a = 0; a < 256; a++) begin
      send(2'd0, 8'(a), 1, 1);
      send(2'd1, 8'(a) ^ 8'h5A, 1, 1);
    end

    // Reset mid-traffic while tx_valid is high.
    send(2'd2, 8'h07, 1, 1);
    send(2'd3, 8'h00, 1, 0);
    chk("pre_reset_tv0", {7'd0, tv0}, 8'h01);
    din = {2'd1, 8'h00};
    rx_valid = 1'b1;
    async_reset();

    for (int v = 0; v < 11; v++) begin
      send(vecs[v].cmd, vecs[v].pl, vecs[v].hold, 1);
      chk($sformatf("vec%0d_dout", v), s_dout0, vecs[v].exp_dout);
      chk($sformatf("vec%0d_tv", v), {7'd0, s_tv0}, {7'd0, vecs[v].exp_tv});
      chk($sformatf("vec%0d_err", v), {7'd0, s_err0}, {7'd0, vecs[v].exp_err});
    end
    send(2'd3, 8'h00, 1, 1);
    chk("held_wr_dout0", s_dout0, 8'h11);
    chk("held_wr_dout1", s_dout1, 8'h11);

    // Held strobe: auto-inc instance must have advanced wr_addr exactly once (3 -> 4).
    send(2'd1, 8'h22, 1, 1);
    send(2'd2, 8'h04, 1, 1);
    send(2'd3, 8'h00, 1, 1);
    chk("inc_addr4_dout1", s_dout1, 8'h22);
    send(2'd2, 8'h08, 1, 1);
    send(2'd3, 8'h00, 1, 1);
    chk("inc_addr8_dout1", s_dout1, 8'h52);

    // Address wrap at 0xFF.
    send(2'd0, 8'hFF, 1, 1);
    send(2'd1, 8'hAA, 1, 1);
    send(2'd1, 8'hBB, 1, 1);
    send(2'd2, 8'hFF, 1, 1);
    send(2'd3, 8'h00, 1, 1);
    chk("wrap_rd0_dout1", s_dout1, 8'hAA);
    chk("wrap_rd0_dout0", s_dout0, 8'hBB);
    send(2'd3, 8'h00, 1, 1);
    chk("wrap_rd1_dout1", s_dout1, 8'hBB);

    // Back-to-back reads two cycles apart keep tx_valid high throughout.
    send(2'd2, 8'h10, 1, 1);
    for (int r = 0; r < 3; r++) begin
      send(2'd3, 8'h00, 1, 1);
      chk($sformatf("b2b%0d_tv0", r), {7'd0, tv0}, 8'h01);
      chk($sformatf("b2b%0d_tv1", r), {7'd0, tv1}, 8'h01);
      chk($sformatf("b2b%0d_dout0", r), s_dout0, 8'h4A);
      chk($sformatf("b2b%0d_dout1", r), s_dout1, (8'h10 + 8'(r)) ^ 8'h5A);
    end

    // Random traffic against the model, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
